// File: rtl/seven_segment_display_scheduler_if.sv
// Bus between the clock/alarm core, the display scheduler and the BCD-to-segment
// decoder. The master side drives the BCD sources and control inputs. The slave
// side (the scheduler) drives the decoder select, the anodes and the frame pulse.
interface seven_segment_display_scheduler_if #(
   parameter int SEGMENT_NUM      = 4,
   parameter int SEGMENT_NUM_USED = 4
);
   logic                            i_Enable;
   logic                            i_Src_Sel;
   logic [4*SEGMENT_NUM_USED-1:0]   i_Time_BCD;
   logic [4*SEGMENT_NUM_USED-1:0]   i_Alarm_BCD;
   logic [SEGMENT_NUM_USED-1:0]     i_Blink_Mask;
   logic [3:0]                      o_BCD_Num_Sel;
   logic [SEGMENT_NUM-1:0]          o_Anodes;
   logic                            o_Frame_Start;

   modport master (
      output i_Enable, i_Src_Sel, i_Time_BCD, i_Alarm_BCD, i_Blink_Mask,
      input  o_BCD_Num_Sel, o_Anodes, o_Frame_Start
   );

   modport slave (
      input  i_Enable, i_Src_Sel, i_Time_BCD, i_Alarm_BCD, i_Blink_Mask,
      output o_BCD_Num_Sel, o_Anodes, o_Frame_Start
   );
endinterface

// File: rtl/seven_segment_display_scheduler.sv
// Multiplexed seven-segment scan scheduler. It scans one digit per slot. Each
// slot is an on-time followed by a blanking gap that suppresses ghosting. The
// BCD source is chosen and snapshotted only at frame boundaries. All outputs
// are registered.
// Optional feature macro: DISPLAY_BLINK_EN. When it is defined, the digits
// selected by the blink mask blank on alternate BLINK_FRAMES-frame half-periods.
module seven_segment_display_scheduler #(
   parameter int SEGMENT_NUM      = 4,
   parameter int SEGMENT_NUM_USED = 4,
   parameter int CLKS_PER_DIGIT   = 100000,
   parameter int BLANK_CLKS       = 1000,
   parameter int BLINK_FRAMES     = 128
) (
   input logic                               i_Clk,
   input logic                               i_Rst_N,
   seven_segment_display_scheduler_if.slave  bus
);

   localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
   localparam int DIG_W = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(CLKS_PER_DIGIT - BLANK_CLKS - 1);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(SEGMENT_NUM - 1);
   localparam logic [3:0]       BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ON    = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t                      state_r, state_nxt_s;
   logic [CNT_W-1:0]            slot_cnt_r, slot_cnt_nxt_s;
   logic [DIG_W-1:0]            digit_r, digit_nxt_s;
   logic                        frame_start_s;
   logic                        first_frame_s;
   logic [3:0]                  snap_r     [SEGMENT_NUM_USED];
   logic [3:0]                  snap_nxt_s [SEGMENT_NUM_USED];
   logic [SEGMENT_NUM_USED-1:0] hide_s;
   logic [SEGMENT_NUM-1:0]      anodes_nxt_s;
   logic [3:0]                  bcd_nxt_s;

   // Scan sequencing: slot counter, digit index and the ON/BLANK phase within each slot.
   always_comb begin
      state_nxt_s    = ST_IDLE;
      slot_cnt_nxt_s = '0;
      digit_nxt_s    = '0;
      frame_start_s  = 1'b0;
      first_frame_s  = 1'b0;
      if (bus.i_Enable) begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s   = ST_ON;
               frame_start_s = 1'b1;
               first_frame_s = 1'b1;
            end
            ST_ON, ST_BLANK: begin
               if (slot_cnt_r == CNT_LAST) begin
                  state_nxt_s    = ST_ON;
                  slot_cnt_nxt_s = '0;
                  if (digit_r == DIG_LAST) begin
                     digit_nxt_s   = '0;
                     frame_start_s = 1'b1;
                  end else begin
                     digit_nxt_s = digit_r + DIG_W'(1);
                  end
               end else begin
                  slot_cnt_nxt_s = slot_cnt_r + CNT_W'(1);
                  digit_nxt_s    = digit_r;
                  // With no blanking, ON_LAST equals CNT_LAST and this branch never blanks.
                  if (slot_cnt_r >= ON_LAST) begin
                     state_nxt_s = ST_BLANK;
                  end else begin
                     state_nxt_s = ST_ON;
                  end
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = ST_IDLE;
      end
   end

   // Scan state register.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         state_r    <= ST_IDLE;
         slot_cnt_r <= '0;
         digit_r    <= '0;
      end else begin
         state_r    <= state_nxt_s;
         slot_cnt_r <= slot_cnt_nxt_s;
         digit_r    <= digit_nxt_s;
      end
   end

   // At a frame start, capture the selected source so mid-frame edits stay hidden.
   always_comb begin
      for (int i = 0; i < SEGMENT_NUM_USED; i++) begin
         if (frame_start_s) begin
            snap_nxt_s[i] = bus.i_Src_Sel ? bus.i_Alarm_BCD[4*i +: 4]
                                          : bus.i_Time_BCD[4*i +: 4];
         end else begin
            snap_nxt_s[i] = snap_r[i];
         end
      end
   end

   // Snapshot register holding the digits shown during the current frame.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         for (int i = 0; i < SEGMENT_NUM_USED; i++) begin
            snap_r[i] <= BCD_BLANK;
         end
      end else begin
         for (int i = 0; i < SEGMENT_NUM_USED; i++) begin
            snap_r[i] <= snap_nxt_s[i];
         end
      end
   end

`ifdef DISPLAY_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   logic [FC_W-1:0]             frame_cnt_r, frame_cnt_nxt_s;
   logic                        blink_phase_r, blink_phase_nxt_s;
   logic [SEGMENT_NUM_USED-1:0] mask_r, mask_nxt_s;

   // Blink timing: count frames and toggle the phase every BLINK_FRAMES frames.
   always_comb begin
      frame_cnt_nxt_s   = frame_cnt_r;
      blink_phase_nxt_s = blink_phase_r;
      mask_nxt_s        = mask_r;
      if (!bus.i_Enable) begin
         frame_cnt_nxt_s   = '0;
         blink_phase_nxt_s = 1'b0;
      end else if (first_frame_s) begin
         frame_cnt_nxt_s   = '0;
         blink_phase_nxt_s = 1'b0;
         mask_nxt_s        = bus.i_Blink_Mask;
      end else if (frame_start_s) begin
         mask_nxt_s = bus.i_Blink_Mask;
         if (frame_cnt_r == FC_LAST) begin
            frame_cnt_nxt_s   = '0;
            blink_phase_nxt_s = ~blink_phase_r;
         end else begin
            frame_cnt_nxt_s = frame_cnt_r + FC_W'(1);
         end
      end else begin
         frame_cnt_nxt_s = frame_cnt_r;
      end
   end

   // Blink counter, blink phase and mask snapshot registers.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         frame_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
         mask_r        <= '0;
      end else begin
         frame_cnt_r   <= frame_cnt_nxt_s;
         blink_phase_r <= blink_phase_nxt_s;
         mask_r        <= mask_nxt_s;
      end
   end

   // Digits to hide in the coming cycle: masked digits while the phase is 1.
   always_comb begin
      if (blink_phase_nxt_s) begin
         hide_s = mask_nxt_s;
      end else begin
         hide_s = '0;
      end
   end
`else
   logic unused_blink_mask_s;

   assign unused_blink_mask_s = ^bus.i_Blink_Mask;
   assign hide_s              = '0;
`endif

   // Output decode for the coming cycle. Only used digits in ON light an anode.
   always_comb begin
      anodes_nxt_s = '1;
      bcd_nxt_s    = BCD_BLANK;
      if (state_nxt_s == ST_ON) begin
         for (int i = 0; i < SEGMENT_NUM_USED; i++) begin
            if (digit_nxt_s == DIG_W'(i)) begin
               anodes_nxt_s[i] = 1'b0;
               if (hide_s[i]) begin
                  bcd_nxt_s = BCD_BLANK;
               end else begin
                  bcd_nxt_s = snap_nxt_s[i];
               end
            end else begin
               bcd_nxt_s = bcd_nxt_s;
            end
         end
      end else begin
         anodes_nxt_s = '1;
         bcd_nxt_s    = BCD_BLANK;
      end
   end

   // Output registers; reset forces the display dark at once.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         bus.o_Anodes      <= '1;
         bus.o_BCD_Num_Sel <= BCD_BLANK;
         bus.o_Frame_Start <= 1'b0;
      end else begin
         bus.o_Anodes      <= anodes_nxt_s;
         bus.o_BCD_Num_Sel <= bcd_nxt_s;
         bus.o_Frame_Start <= frame_start_s;
      end
   end

endmodule

// File: tb/tb_seven_segment_display_scheduler.sv
// Self-checking bench for seven_segment_display_scheduler. Two instances share
// the same stimulus: one with a blanking gap and one without. A frame-level
// reference model predicts every output on every cycle, and literal checks pin
// the model at known points of the scan.
module tb_seven_segment_display_scheduler;

   localparam int SN    = 4;
   localparam int USED  = 3;
   localparam int CPD   = 8;
   localparam int BLANK = 2;
   localparam int BF    = 2;
   localparam int FRAME = SN * CPD;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               src;
   logic [4*USED-1:0]  time_bcd;
   logic [4*USED-1:0]  alarm_bcd;
   logic [USED-1:0]    mask;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit         act_m;
   int         t_m;
   int         frame_m;
   logic [3:0] snap_m [USED];
   logic [USED-1:0] mask_m;

   seven_segment_display_scheduler_if #(.SEGMENT_NUM(SN), .SEGMENT_NUM_USED(USED)) bus0 ();
   seven_segment_display_scheduler_if #(.SEGMENT_NUM(SN), .SEGMENT_NUM_USED(USED)) bus1 ();

   assign bus0.i_Enable     = en;
   assign bus0.i_Src_Sel    = src;
   assign bus0.i_Time_BCD   = time_bcd;
   assign bus0.i_Alarm_BCD  = alarm_bcd;
   assign bus0.i_Blink_Mask = mask;
   assign bus1.i_Enable     = en;
   assign bus1.i_Src_Sel    = src;
   assign bus1.i_Time_BCD   = time_bcd;
   assign bus1.i_Alarm_BCD  = alarm_bcd;
   assign bus1.i_Blink_Mask = mask;

   seven_segment_display_scheduler #(
      .SEGMENT_NUM(SN), .SEGMENT_NUM_USED(USED), .CLKS_PER_DIGIT(CPD),
      .BLANK_CLKS(BLANK), .BLINK_FRAMES(BF)
   ) dut0 (
      .i_Clk(clk), .i_Rst_N(rst_n), .bus(bus0)
   );

   seven_segment_display_scheduler #(
      .SEGMENT_NUM(SN), .SEGMENT_NUM_USED(USED), .CLKS_PER_DIGIT(CPD),
      .BLANK_CLKS(0), .BLINK_FRAMES(BF)
   ) dut1 (
      .i_Clk(clk), .i_Rst_N(rst_n), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act_v, exp_v, $time);
      end
   endtask

   // Model: time within the scan since enable, frame number and per-frame snapshot.
   task automatic latch_frame();
      logic [4*USED-1:0] srcv;
      srcv = src ? alarm_bcd : time_bcd;
      for (int i = 0; i < USED; i++) snap_m[i] = srcv[4*i +: 4];
      mask_m = mask;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_m = 1'b0; t_m = 0; frame_m = 0; mask_m = '0;
         for (int i = 0; i < USED; i++) snap_m[i] = 4'hF;
      end else if (!en) begin
         act_m = 1'b0; t_m = 0; frame_m = 0;
      end else if (!act_m) begin
         act_m = 1'b1; t_m = 0; frame_m = 0;
         latch_frame();
      end else begin
         t_m++;
         if (t_m % FRAME == 0) begin
            frame_m++;
            latch_frame();
         end
      end
   end

   function automatic void model_expect(input int blank, output logic [3:0] an,
                                        output logic [3:0] bcd, output logic fs);
      int pos, d, c;
      bit phase;
      an = 4'hF; bcd = 4'hF; fs = 1'b0;
      if (act_m) begin
         pos = t_m % FRAME;
         d   = pos / CPD;
         c   = pos % CPD;
         fs  = (pos == 0);
`ifdef DISPLAY_BLINK_EN
         phase = ((frame_m / BF) % 2) == 1;
`else
         phase = 1'b0;
`endif
         if (c < CPD - blank && d < USED) begin
            an[d] = 1'b0;
            if (!(phase && mask_m[d])) bcd = snap_m[d];
         end
      end
   endfunction

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      logic [3:0] ea, eb;
      logic       ef;
      model_expect(BLANK, ea, eb, ef);
      check("dut0_anodes", 32'(bus0.o_Anodes), 32'(ea));
      check("dut0_bcd",    32'(bus0.o_BCD_Num_Sel), 32'(eb));
      check("dut0_fs",     32'(bus0.o_Frame_Start), 32'(ef));
      model_expect(0, ea, eb, ef);
      check("dut1_anodes", 32'(bus1.o_Anodes), 32'(ea));
      check("dut1_bcd",    32'(bus1.o_BCD_Num_Sel), 32'(eb));
      check("dut1_fs",     32'(bus1.o_Frame_Start), 32'(ef));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pin0(input string name, input logic [3:0] an, input logic [3:0] bcd, input logic fs);
      check({name, "_an"},  32'(bus0.o_Anodes), 32'(an));
      check({name, "_bcd"}, 32'(bus0.o_BCD_Num_Sel), 32'(bcd));
      check({name, "_fs"},  32'(bus0.o_Frame_Start), 32'(fs));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; src = 1'b0;
      time_bcd = 12'h321; alarm_bcd = 12'h987; mask = 3'b010;
      step(3);
      pin0("reset", 4'b1111, 4'hF, 1'b0);
      rst_n = 1'b1;
      step(2);
      pin0("idle", 4'b1111, 4'hF, 1'b0);

      // scan order and frame-boundary source switch
      en = 1'b1;
      step(1);                                      // t=0
      pin0("t0", 4'b1110, 4'h1, 1'b1);
      step(6);                                      // t=6 blank of digit 0
      pin0("t6", 4'b1111, 4'hF, 1'b0);
      check("t6_dut1_an", 32'(bus1.o_Anodes), 32'(4'b1110));
      step(4);                                      // t=10 digit 1
      pin0("t10", 4'b1101, 4'h2, 1'b0);
      check("t10_dut1_an", 32'(bus1.o_Anodes), 32'(4'b1101));
      src = 1'b1;
      step(6);                                      // t=16 digit 2, old source
      pin0("t16", 4'b1011, 4'h3, 1'b0);
      step(8);                                      // t=24 unused digit 3
      pin0("t24", 4'b1111, 4'hF, 1'b0);
      check("t24_dut1_an", 32'(bus1.o_Anodes), 32'(4'b1111));
      step(8);                                      // t=32 next frame, alarm
      pin0("t32", 4'b1110, 4'h7, 1'b1);
      step(40);                                     // t=72 frame 2 digit 1
`ifdef DISPLAY_BLINK_EN
      pin0("t72", 4'b1101, 4'hF, 1'b0);
`else
      pin0("t72", 4'b1101, 4'h8, 1'b0);
`endif

      // enable drop in blank of digit 2, then restart
      step(46);                                     // t=118
      pin0("t118", 4'b1111, 4'hF, 1'b0);
      en = 1'b0;
      step(1);
      pin0("drop", 4'b1111, 4'hF, 1'b0);
      step(3);
      en = 1'b1;
      step(1);
      pin0("reen0", 4'b1110, 4'h7, 1'b1);
      step(10);
      pin0("reen10", 4'b1101, 4'h8, 1'b0);

      // randomized traffic checked by the model
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if (en) begin
            if ($urandom_range(0, 199) == 0) en = 1'b0;
         end else begin
            if ($urandom_range(0, 9) == 0) en = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) src = ~src;
         if ($urandom_range(0, 19) == 0) time_bcd = 12'($urandom);
         if ($urandom_range(0, 19) == 0) alarm_bcd = 12'($urandom);
         if ($urandom_range(0, 29) == 0) mask = 3'($urandom);
      end

      // asynchronous reset mid-scan
      en = 1'b1; src = 1'b0; time_bcd = 12'h654;
      step(13);
      #2 rst_n = 1'b0;
      #1 pin0("async_rst", 4'b1111, 4'hF, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(1);
      pin0("rst_rel", 4'b1110, 4'h4, 1'b1);
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
